// File: rtl/instr_display_writer_if.sv
// Bundle of operator-facing signals for instr_display_writer: raw keys,
// live instruction fields, datapath result strobe, and the seven-segment /
// LED outputs. The master modport is the board side driving the inputs; the
// slave modport is the display writer itself.
interface instr_display_writer_if;
    logic [3:0]  KEY;
    logic [3:0]  codop;
    logic [3:0]  addA;
    logic [3:0]  addB_LMM;
    logic [3:0]  addC;
    logic [15:0] result;
    logic        result_valid;
    logic [6:0]  HEX3;
    logic [6:0]  HEX2;
    logic [6:0]  HEX1;
    logic [6:0]  HEX0;
    logic [3:0]  LEDG;

    modport master (
        output KEY, codop, addA, addB_LMM, addC, result, result_valid,
        input  HEX3, HEX2, HEX1, HEX0, LEDG
    );

    modport slave (
        input  KEY, codop, addA, addB_LMM, addC, result, result_valid,
        output HEX3, HEX2, HEX1, HEX0, LEDG
    );
endinterface

// File: rtl/instr_display_writer.sv
// Output path of the I2O2 CPU board: debounces the capture/page keys, keeps a
// captured instruction and the last datapath result, and shows one of three
// pages (live fields, captured instruction, result) on four active-low
// seven-segment digits plus a one-hot page indicator and a dirty flag.
module instr_display_writer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input logic                   CLOCK_50,
    input logic                   reset,
    instr_display_writer_if.slave bus
);

    // Counter only has to hold values up to DEBOUNCE_CYCLES-1.
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        PAGE_LIVE   = 2'd0,
        PAGE_INSTR  = 2'd1,
        PAGE_RESULT = 2'd2
    } page_t;

    // Active-low segment pattern, bit6..bit0 = g..a.
    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // KEY[3:2] have no function on this board.
    logic unused_keys;
    assign unused_keys = &bus.KEY[3:2];

    // press[0] = capture, press[1] = next page; one-cycle pulses.
    logic [1:0] press;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_key
            logic          s1_reg;
            logic          s2_reg;
            logic          stable_reg;
            logic          stable_q_reg;
            logic [CW-1:0] cnt_reg;

            // Synchronize the raw key, then accept a new level only after it
            // has differed from the accepted level for DEBOUNCE_CYCLES cycles
            // in a row; any agreeing cycle restarts the qualification.
            always_ff @(posedge CLOCK_50) begin
                if (reset) begin
                    s1_reg       <= 1'b1;
                    s2_reg       <= 1'b1;
                    stable_reg   <= 1'b1;
                    stable_q_reg <= 1'b1;
                    cnt_reg      <= '0;
                end else begin
                    s1_reg       <= bus.KEY[gi];
                    s2_reg       <= s1_reg;
                    stable_q_reg <= stable_reg;
                    if (s2_reg == stable_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        stable_reg <= s2_reg;
                        cnt_reg    <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
            end

            // Falling edge of the accepted level only; release is silent.
            assign press[gi] = stable_q_reg & ~stable_reg;
        end
    endgenerate

    logic [15:0] live_fields;
    assign live_fields = {bus.codop, bus.addA, bus.addB_LMM, bus.addC};

    page_t       page_reg;
    logic [15:0] instr_reg;
    logic [15:0] res_reg;

    // Page FSM plus the captured instruction and result. A result strobe
    // always lands on RESULT; otherwise capture beats the page key.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            page_reg  <= PAGE_LIVE;
            instr_reg <= '0;
            res_reg   <= '0;
        end else begin
            if (press[0]) begin
                instr_reg <= live_fields;
            end
            if (bus.result_valid) begin
                res_reg <= bus.result;
            end

            if (bus.result_valid) begin
                page_reg <= PAGE_RESULT;
            end else if (press[0]) begin
                page_reg <= PAGE_INSTR;
            end else if (press[1]) begin
                case (page_reg)
                    PAGE_LIVE:   page_reg <= PAGE_INSTR;
                    PAGE_INSTR:  page_reg <= PAGE_RESULT;
                    default:     page_reg <= PAGE_LIVE;
                endcase
            end
        end
    end

    logic [15:0] disp_next;
    logic [3:0]  ledg_next;

    // Pick the nibbles for the current page and build the LED pattern.
    always_comb begin
        disp_next = live_fields;
        ledg_next = 4'b0000;
        case (page_reg)
            PAGE_INSTR: begin
                disp_next    = instr_reg;
                ledg_next[1] = 1'b1;
            end
            PAGE_RESULT: begin
                disp_next    = res_reg;
                ledg_next[2] = 1'b1;
            end
            default: begin
                disp_next    = live_fields;
                ledg_next[0] = 1'b1;
            end
        endcase
        ledg_next[3] = (live_fields != instr_reg);
    end

    logic [6:0] hex_reg [4];
    logic [3:0] ledg_reg;

    // Registered segment and LED outputs; blank and dark while in reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                hex_reg[i] <= 7'h7F;
            end
            ledg_reg <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                hex_reg[i] <= seg7(disp_next[i*4 +: 4]);
            end
            ledg_reg <= ledg_next;
        end
    end

    assign bus.HEX3 = hex_reg[3];
    assign bus.HEX2 = hex_reg[2];
    assign bus.HEX1 = hex_reg[1];
    assign bus.HEX0 = hex_reg[0];
    assign bus.LEDG = ledg_reg;

endmodule

// File: tb/tb_instr_display_writer.sv
// Directed bench for instr_display_writer with DEBOUNCE_CYCLES = 4. Inputs
// change on the falling clock edge and outputs are sampled there as well, so
// "edge 0" below is the rising edge just before a key is driven low: s2 is low
// after edge 2, stable falls at edge 6, page/instr update at edge 7 and the
// digits at edge 8.
module tb_instr_display_writer;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    instr_display_writer_if bus ();

    instr_display_writer #(.DEBOUNCE_CYCLES(4)) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %-18s value=%08h", tag, got);
        end else begin
            $display("FAIL %-18s got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic [6:0] h3, input logic [6:0] h2,
                                         input logic [6:0] h1, input logic [6:0] h0,
                                         input logic [3:0] led);
        return {h3, h2, h1, h0, led};
    endfunction

    function automatic logic [31:0] disp();
        return {bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0, bus.LEDG};
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // A50F on the digits: 08,12,40,0E.
    logic [31:0] exp_live9, exp_instr2, exp_res_beef, exp_live1;

    // One KEY[1] page press: check 8 edges later, hold, release, check again.
    task automatic page_press(input string tag, input logic [31:0] exp);
        bus.KEY[1] = 1'b0;
        step(8);
        check({tag, "_now"}, disp(), exp);
        step(10);
        bus.KEY[1] = 1'b1;
        step(12);
        check({tag, "_after"}, disp(), exp);
    endtask

    initial begin
        exp_live9    = pack(7'h08, 7'h12, 7'h40, 7'h0E, 4'h9);
        exp_live1    = pack(7'h08, 7'h12, 7'h40, 7'h0E, 4'h1);
        exp_instr2   = pack(7'h08, 7'h12, 7'h40, 7'h0E, 4'h2);
        exp_res_beef = pack(7'h03, 7'h06, 7'h06, 7'h0E, 4'h4);

        rst              = 1'b1;
        bus.KEY          = 4'hF;
        bus.codop        = 4'h1;
        bus.addA         = 4'h2;
        bus.addB_LMM     = 4'h3;
        bus.addC         = 4'h4;
        bus.result       = 16'h0000;
        bus.result_valid = 1'b0;

        // Reset: blank digits, LEDs dark.
        step(3);
        check("reset_hold", disp(), pack(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'h0));
        rst = 1'b0;
        step(1);
        // LIVE page; fields 1234 differ from the cleared instr_q so dirty is set.
        check("reset_release", disp(), pack(7'h79, 7'h24, 7'h30, 7'h19, 4'h9));

        // Short glitch on KEY[0] (3 cycles < D): nothing captured.
        bus.codop = 4'hA; bus.addA = 4'h5; bus.addB_LMM = 4'h0; bus.addC = 4'hF;
        bus.KEY[0] = 1'b0;
        step(3);
        bus.KEY[0] = 1'b1;
        step(12);
        check("short_glitch", disp(), exp_live9);

        // Long press: digits unchanged through edge 7, INSTR page at edge 8.
        bus.KEY[0] = 1'b0;
        step(7);
        check("press_edge7", disp(), exp_live9);
        step(1);
        check("press_edge8", disp(), exp_instr2);
        step(12);
        bus.KEY[0] = 1'b1;
        step(12);
        check("hold_release", disp(), exp_instr2);

        // Dirty flag follows the live fields; INSTR digits do not.
        bus.codop = 4'h3;
        step(1);
        check("dirty_set", disp(), pack(7'h08, 7'h12, 7'h40, 7'h0E, 4'hA));
        bus.codop = 4'hA;
        step(1);
        check("dirty_clear", disp(), exp_instr2);

        // Result strobe: page moves at the strobe edge, digits one edge later.
        bus.result       = 16'hBEEF;
        bus.result_valid = 1'b1;
        step(1);
        bus.result_valid = 1'b0;
        check("result_edge_n", disp(), exp_instr2);
        step(1);
        check("result_shown", disp(), exp_res_beef);

        // Paging RESULT -> LIVE -> INSTR -> RESULT, one event per press.
        page_press("page_live", exp_live1);
        page_press("page_instr", exp_instr2);
        page_press("page_result", exp_res_beef);
        page_press("page_live2", exp_live1);

        // Collision: result_valid coincides with the KEY[1] press pulse.
        bus.KEY[1] = 1'b0;
        step(6);
        bus.result       = 16'h0012;
        bus.result_valid = 1'b1;
        step(1);
        bus.result_valid = 1'b0;
        step(1);
        check("collide", disp(), pack(7'h40, 7'h40, 7'h79, 7'h24, 4'h4));
        step(3);
        check("collide_hold", disp(), pack(7'h40, 7'h40, 7'h79, 7'h24, 4'h4));
        bus.KEY[1] = 1'b1;
        step(12);

        // Reset in the middle of a KEY[0] press: key must re-qualify.
        bus.KEY[0] = 1'b0;
        step(4);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
        check("rst_mid_press", disp(), exp_live9);
        step(6);
        check("requal_edge7", disp(), exp_live9);
        step(1);
        check("requal_edge8", disp(), exp_instr2);
        bus.KEY[0] = 1'b1;
        step(12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
